// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential repeated-subtraction divider.
package seq_div_pkg;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle of the divider: operands and start in, status and results out.
interface seq_div_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_div_datapath.sv
// Remainder/divisor/quotient registers with the >= comparator and subtractor.
module seq_div_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             set_zero,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ge,
    output logic             dzero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dz_q,  dz_d;

    assign ge    = (rem_q >= dvs_q);
    assign dzero = (dvs_q == '0);

    always_comb begin
        rem_d = rem_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        dz_d  = dz_q;
        if (load) begin
            rem_d = dividend_i;
            dvs_d = divisor_i;
            quo_d = '0;
            dz_d  = 1'b0;
        end else if (set_zero) begin
            quo_d = '1;
            dz_d  = 1'b1;
        end else if (step) begin
            // Only asserted when ge holds, so this never wraps.
            rem_d = rem_q - dvs_q;
            quo_d = quo_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            dz_q  <= dz_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: control FSM steering one subtraction per clock.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic     clk,
    input  logic     clear,
    seq_div_if.slave bus
);
    state_t state_q, state_d;
    logic   load, step, set_zero;
    logic   ge, dzero;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        set_zero = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Zero divisor takes priority so it never loops forever.
                if (dzero) begin
                    set_zero = 1'b1;
                    state_d  = S_DONE;
                end else if (ge) begin
                    step = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);

    seq_div_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .clear      (clear),
        .load       (load),
        .step       (step),
        .set_zero   (set_zero),
        .dividend_i (bus.dividend),
        .divisor_i  (bus.divisor),
        .ge         (ge),
        .dzero      (dzero),
        .quotient   (bus.quotient),
        .remainder  (bus.remainder),
        .div_zero   (bus.div_zero)
    );
endmodule
